// File: rtl/data_memory_controller_pkg.sv
// Shared GPU data-memory types and the per-channel FSM state encoding used by
// the data memory controller.
package data_memory_controller_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int ADDR_WIDTH = 8;

   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [ADDR_WIDTH-1:0] data_memory_address_t;

   typedef enum logic [2:0] {
      IDLE,
      READ_WAITING,
      WRITE_WAITING,
      READ_RELAYING,
      WRITE_RELAYING
   } mem_channel_state_t;

endpackage

// File: rtl/data_memory_controller_memory_channel.sv
// One external memory channel: latches a granted lane request, holds it on the
// memory port until accepted, then relays completion until the lane lets go.
module memory_channel
   import data_memory_controller_pkg::*;
#(
   parameter int LANE_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 grant_i,
   input  logic                 grant_read_i,
   input  logic [LANE_W-1:0]    grant_lane_i,
   input  data_memory_address_t grant_read_addr_i,
   input  data_memory_address_t grant_write_addr_i,
   input  data_t                grant_write_data_i,
   input  logic                 owner_read_valid_i,
   input  logic                 owner_write_valid_i,
   output logic                 idle_o,
   output logic                 release_o,
   output logic [LANE_W-1:0]    owner_o,
   output logic                 mem_read_valid_o,
   output data_memory_address_t mem_read_address_o,
   input  logic                 mem_read_ready_i,
   input  data_t                mem_read_data_i,
   output logic                 mem_write_valid_o,
   output data_memory_address_t mem_write_address_o,
   output data_t                mem_write_data_o,
   input  logic                 mem_write_ready_i,
   output logic                 relay_read_o,
   output logic                 relay_write_o,
   output data_t                read_data_o
);

   mem_channel_state_t   state_q;
   logic [LANE_W-1:0]    owner_q;
   data_memory_address_t addr_q;
   data_t                wdata_q;
   data_t                rdata_q;
   logic                 mem_rv_q;
   logic                 mem_wv_q;
   logic                 relay_r_q;
   logic                 relay_w_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; datapath registers are reset too so the address
   // and data outputs are defined zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         mem_rv_q  <= 1'b0;
         mem_wv_q  <= 1'b0;
         relay_r_q <= 1'b0;
         relay_w_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_i) begin
                  owner_q <= grant_lane_i;
                  if (grant_read_i) begin
                     addr_q   <= grant_read_addr_i;
                     mem_rv_q <= 1'b1;
                     state_q  <= READ_WAITING;
                  end else begin
                     addr_q   <= grant_write_addr_i;
                     wdata_q  <= grant_write_data_i;
                     mem_wv_q <= 1'b1;
                     state_q  <= WRITE_WAITING;
                  end
               end
            end
            READ_WAITING: begin
               if (mem_read_ready_i) begin
                  mem_rv_q  <= 1'b0;
                  rdata_q   <= mem_read_data_i;
                  relay_r_q <= 1'b1;
                  state_q   <= READ_RELAYING;
               end
            end
            WRITE_WAITING: begin
               if (mem_write_ready_i) begin
                  mem_wv_q  <= 1'b0;
                  relay_w_q <= 1'b1;
                  state_q   <= WRITE_RELAYING;
               end
            end
            READ_RELAYING: begin
               if (!owner_read_valid_i) begin
                  relay_r_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            WRITE_RELAYING: begin
               if (!owner_write_valid_i) begin
                  relay_w_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign idle_o    = (state_q == IDLE);
   assign release_o = ((state_q == READ_RELAYING)  && !owner_read_valid_i) ||
                      ((state_q == WRITE_RELAYING) && !owner_write_valid_i);
   assign owner_o   = owner_q;

   // Address/data are only presented while the matching request is outstanding.
   assign mem_read_valid_o    = mem_rv_q;
   assign mem_read_address_o  = mem_rv_q ? addr_q : '0;
   assign mem_write_valid_o   = mem_wv_q;
   assign mem_write_address_o = mem_wv_q ? addr_q : '0;
   assign mem_write_data_o    = mem_wv_q ? wdata_q : '0;

   assign relay_read_o  = relay_r_q;
   assign relay_write_o = relay_w_q;
   assign read_data_o   = relay_r_q ? rdata_q : '0;

endmodule

// File: rtl/data_memory_controller.sv
// Arbitrates per-lane data-memory requests onto NUM_CHANNELS memory channels
// with fixed lowest-lane priority and a lane_busy ownership mask.
module data_memory_controller
   import data_memory_controller_pkg::*;
#(
   parameter int NUM_CONSUMERS = 32,
   parameter int NUM_CHANNELS  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CONSUMERS-1:0]   consumer_read_valid,
   input  data_memory_address_t       consumer_read_address  [NUM_CONSUMERS],
   output logic [NUM_CONSUMERS-1:0]   consumer_read_ready,
   output data_t                      consumer_read_data     [NUM_CONSUMERS],
   input  logic [NUM_CONSUMERS-1:0]   consumer_write_valid,
   input  data_memory_address_t       consumer_write_address [NUM_CONSUMERS],
   input  data_t                      consumer_write_data    [NUM_CONSUMERS],
   output logic [NUM_CONSUMERS-1:0]   consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]    mem_read_valid,
   output data_memory_address_t       mem_read_address       [NUM_CHANNELS],
   input  logic [NUM_CHANNELS-1:0]    mem_read_ready,
   input  data_t                      mem_read_data          [NUM_CHANNELS],
   output logic [NUM_CHANNELS-1:0]    mem_write_valid,
   output data_memory_address_t       mem_write_address      [NUM_CHANNELS],
   output data_t                      mem_write_data         [NUM_CHANNELS],
   input  logic [NUM_CHANNELS-1:0]    mem_write_ready
);

   localparam int LANE_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   logic [NUM_CONSUMERS-1:0] lane_busy_q, lane_busy_d;
   logic [NUM_CONSUMERS-1:0] taken;
   logic [NUM_CHANNELS-1:0]  chan_idle, chan_release;
   logic [NUM_CHANNELS-1:0]  grant_valid, grant_read;
   logic [NUM_CHANNELS-1:0]  owner_read_valid, owner_write_valid;
   logic [NUM_CHANNELS-1:0]  relay_read, relay_write;
   logic [LANE_W-1:0]        grant_lane [NUM_CHANNELS];
   logic [LANE_W-1:0]        owner      [NUM_CHANNELS];
   data_t                    relay_data [NUM_CHANNELS];

   // Channels claim lanes in index order; `taken` carries claims down the chain.
   // NOTE: every signal written in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      taken = lane_busy_q;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         grant_valid[c] = 1'b0;
         grant_read[c]  = 1'b0;
         grant_lane[c]  = '0;
         if (chan_idle[c]) begin
            for (int l = 0; l < NUM_CONSUMERS; l++) begin
               if (!grant_valid[c] && !taken[l] &&
                   (consumer_read_valid[l] || consumer_write_valid[l])) begin
                  grant_valid[c] = 1'b1;
                  grant_read[c]  = consumer_read_valid[l];
                  grant_lane[c]  = LANE_W'(l);
                  taken[l]       = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      lane_busy_d = lane_busy_q;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (chan_release[c]) lane_busy_d[owner[c]] = 1'b0;
         if (grant_valid[c])  lane_busy_d[grant_lane[c]] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) lane_busy_q <= '0;
      else        lane_busy_q <= lane_busy_d;
   end

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      assign owner_read_valid[c]  = consumer_read_valid[owner[c]];
      assign owner_write_valid[c] = consumer_write_valid[owner[c]];

      memory_channel #(.LANE_W(LANE_W)) u_channel (
         .clk                 (clk),
         .rst_n               (reset),
         .grant_i             (grant_valid[c]),
         .grant_read_i        (grant_read[c]),
         .grant_lane_i        (grant_lane[c]),
         .grant_read_addr_i   (consumer_read_address[grant_lane[c]]),
         .grant_write_addr_i  (consumer_write_address[grant_lane[c]]),
         .grant_write_data_i  (consumer_write_data[grant_lane[c]]),
         .owner_read_valid_i  (owner_read_valid[c]),
         .owner_write_valid_i (owner_write_valid[c]),
         .idle_o              (chan_idle[c]),
         .release_o           (chan_release[c]),
         .owner_o             (owner[c]),
         .mem_read_valid_o    (mem_read_valid[c]),
         .mem_read_address_o  (mem_read_address[c]),
         .mem_read_ready_i    (mem_read_ready[c]),
         .mem_read_data_i     (mem_read_data[c]),
         .mem_write_valid_o   (mem_write_valid[c]),
         .mem_write_address_o (mem_write_address[c]),
         .mem_write_data_o    (mem_write_data[c]),
         .mem_write_ready_i   (mem_write_ready[c]),
         .relay_read_o        (relay_read[c]),
         .relay_write_o       (relay_write[c]),
         .read_data_o         (relay_data[c])
      );
   end

   // Each lane has at most one owning channel, so the relay fan-in cannot collide.
   always_comb begin
      consumer_read_ready  = '0;
      consumer_write_ready = '0;
      for (int l = 0; l < NUM_CONSUMERS; l++) consumer_read_data[l] = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (relay_read[c]) begin
            consumer_read_ready[owner[c]] = 1'b1;
            consumer_read_data[owner[c]]  = relay_data[c];
         end
         if (relay_write[c]) consumer_write_ready[owner[c]] = 1'b1;
      end
   end

endmodule
